mem_bus_arbiter: RTL and testbench
==================================

Name: mem_bus_arbiter

Overview:
- Shares one external memory port between the fetch stage (instruction reads) and the memory stage (loads/stores).
- Sits between the datapath and the external memory pins.
- Drives the shared bus handshake and returns per-requester ready pulses.
- The ready pulses feed the stall logic.
- Arbitration: data side has fixed priority, with an anti-starvation override for fetch and a bus timeout.

Parameters:
STARVE_LIMIT, 4, consecutive D grants while I waits before I gets forced priority (1..15)
TIMEOUT, 64, BUSY cycles without ack before the transaction is aborted (2..255)

Ports:
clk  in  1  clock, rising edge
reset_x  in  1  asynchronous active-low reset
i_req  in  1  fetch request, held until i_ready
i_addr  in  32  fetch address
i_rdata  out  32  fetched word
i_ready  out  1  one-cycle completion pulse, fetch side
d_req  in  1  data request, held until d_ready
d_write  in  1  1=store, 0=load
d_size  in  2  access size, passed through unchanged
d_addr  in  32  data address
d_wdata  in  32  store data
d_rdata  out  32  load data
d_ready  out  1  one-cycle completion pulse, data side
mem_req  out  1  bus request
mem_write  out  1  bus write strobe, high only for D stores
mem_size  out  2  bus size; 2'b10 (word) for fetch
mem_addr  out  32  bus address
mem_wdata  out  32  bus write data
mem_rdata  in  32  bus read data
mem_ack_n  in  1  bus acknowledge, active-low
bus_err  out  1  one-cycle pulse on timeout abort
busy  out  1  high in IBUSY or DBUSY

Behaviour:
- Reset (reset_x=0, async) sets the following, regardless of the current state (mid-transaction reset abandons the bus access with no ready pulse):
  - state=IDLE
  - all outputs 0 (rdata 32'h0, mem_* 0, ready/err 0)
  - starve counter 0, timeout counter 0
- States: IDLE, IBUSY, DBUSY.
- IDLE grant rules:
  - Forced fetch: starve_cnt==STARVE_LIMIT and i_req -> IBUSY.
  - Otherwise data first: d_req -> DBUSY; else i_req -> IBUSY.
  - On grant, register the requester's addr/write/size/wdata onto mem_*.
  - mem_req=1 from the first BUSY cycle.
- Ready-cycle masking: a requester's req is ignored in the IDLE cycle where its own ready is high. This prevents regrant of a held req. The other requester may be granted in that cycle.
- BUSY:
  - Bus outputs stay constant until completion.
  - The timeout counter increments each BUSY cycle.
- Completion:
  - Trigger: mem_ack_n==0 sampled at a BUSY edge.
  - Register mem_rdata into the granted side's rdata (stores: rdata unchanged).
  - That side's ready=1 for exactly the next cycle.
  - mem_req/mem_write go to 0; state -> IDLE; timeout counter cleared.
- Timeout:
  - Trigger: timeout counter reaches TIMEOUT-1 with no ack.
  - Drop mem_req; next cycle pulse bus_err and the granted side's ready; rdata 32'h0; state -> IDLE.
- Latency: grant on the edge after req seen in IDLE; ack in the first BUSY cycle gives ready 2 cycles after req. Back-to-back same-side throughput: 1 access per 3 cycles at zero wait.
- Starve counter:
  - +1 on each D grant while i_req=1.
  - Cleared on any I grant.
  - Saturates at STARVE_LIMIT.
- Simultaneous d_req and i_req in IDLE: D wins unless forced fetch.
- Drop rules:
  - A req dropped during BUSY does not abort; the transaction completes and ready still pulses.
  - Any req dropped before grant is never issued.
- mem_ack_n low while IDLE is ignored.
- mem_wdata is 0 on fetch grants.

Test Plan:
1. Reset: reset_x=0 mid-DBUSY with mem_req=1 -> mem_req, busy, d_ready drop to 0 asynchronously; after release, IDLE, no ready pulse.
2. Single fetch: i_req, i_addr=32'h0000_0100, ack_n low 1st BUSY cycle with mem_rdata=32'h0000_0013 -> mem_req 1 cycle, mem_size=2'b10, mem_write=0; i_rdata=32'h13, i_ready 1 cycle at req+2.
3. Contention: d_req(store, addr 32'h1000, wdata 32'hDEADBEEF) and i_req same cycle -> D granted first with mem_write=1; I granted in the d_ready cycle; i_ready follows 3 cycles after d_ready.
4. Starvation: d_req held high, new D each opportunity, i_req held, STARVE_LIMIT=4 -> exactly 4 D grants, then I granted; starve counter returns to 0.
5. Wait states: ack_n held high 5 BUSY cycles then low -> bus outputs stable 6 cycles; ready one cycle after ack; no bus_err.
6. Timeout: TIMEOUT=64, ack_n never asserted on a load -> mem_req drops after 64 BUSY cycles; bus_err and d_ready pulse together; d_rdata=32'h0; next request serviced normally.

Source files
------------

// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter
//   Shares one external memory port between the fetch stage (I side) and the
//   memory stage (D side). The D side has fixed priority. I is forced through
//   after STARVE_LIMIT D grants that happened while it was waiting. A bus
//   access that gets no acknowledge within TIMEOUT busy cycles is aborted
//   with a bus_err pulse.
//
//   Handshake: a requester raises *_req with its address, and data for a
//   store, and holds all of them stable until it sees its *_ready pulse. The
//   pulse lasts exactly one cycle and marks completion; rdata is valid from
//   that cycle on. On the bus side, mem_req and every mem_* field stay
//   constant from the first busy cycle until an edge samples mem_ack_n low
//   (or the access is aborted).
//
// Ports
//   clk, reset_x          rising-edge clock, asynchronous active-low reset
//   i_req/i_addr          fetch request and address (word reads only)
//   i_rdata/i_ready       fetched word, one-cycle completion pulse
//   d_req/d_write/d_size/d_addr/d_wdata   load/store request
//   d_rdata/d_ready       load data, one-cycle completion pulse
//   mem_req/mem_write/mem_size/mem_addr/mem_wdata   bus request fields
//   mem_rdata/mem_ack_n   bus read data, active-low acknowledge
//   bus_err               one-cycle pulse together with ready on a timeout abort
//   busy                  a bus access is in flight
module mem_bus_arbiter #(
  parameter int unsigned STARVE_LIMIT = 4,  // 1..15
  parameter int unsigned TIMEOUT      = 64  // 2..255
) (
  input  logic        clk,
  input  logic        reset_x,
  input  logic        i_req,
  input  logic [31:0] i_addr,
  output logic [31:0] i_rdata,
  output logic        i_ready,
  input  logic        d_req,
  input  logic        d_write,
  input  logic [1:0]  d_size,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic [31:0] d_rdata,
  output logic        d_ready,
  output logic        mem_req,
  output logic        mem_write,
  output logic [1:0]  mem_size,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack_n,
  output logic        bus_err,
  output logic        busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    IBUSY = 2'd1,
    DBUSY = 2'd2
  } state_e;

  localparam logic [3:0] STARVE_MAX = 4'(STARVE_LIMIT);
  localparam logic [7:0] TMO_LAST   = 8'(TIMEOUT - 1);

  state_e      state_q, state_d;
  logic [3:0]  starve_q, starve_d;
  logic [7:0]  tmo_q, tmo_d;
  logic [31:0] i_rdata_q, i_rdata_d;
  logic [31:0] d_rdata_q, d_rdata_d;
  logic        i_ready_q, i_ready_d;
  logic        d_ready_q, d_ready_d;
  logic        bus_err_q, bus_err_d;
  logic        mem_req_q, mem_req_d;
  logic        mem_write_q, mem_write_d;
  logic [1:0]  mem_size_q, mem_size_d;
  logic [31:0] mem_addr_q, mem_addr_d;
  logic [31:0] mem_wdata_q, mem_wdata_d;

  // A requester still holds its req during its own ready cycle; masking it
  // there keeps a finished access from being granted a second time.
  logic i_req_eff, d_req_eff, force_i, grant_i, grant_d;

  assign i_req_eff = i_req & ~i_ready_q;
  assign d_req_eff = d_req & ~d_ready_q;
  assign force_i   = i_req_eff && (starve_q == STARVE_MAX);
  assign grant_i   = force_i || (i_req_eff && !d_req_eff);
  assign grant_d   = d_req_eff && !force_i;

  always_comb begin
    state_d     = state_q;
    starve_d    = starve_q;
    tmo_d       = tmo_q;
    i_rdata_d   = i_rdata_q;
    d_rdata_d   = d_rdata_q;
    i_ready_d   = 1'b0;
    d_ready_d   = 1'b0;
    bus_err_d   = 1'b0;
    mem_req_d   = mem_req_q;
    mem_write_d = mem_write_q;
    mem_size_d  = mem_size_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;

    unique case (state_q)
      IDLE: begin
        // mem_ack_n is deliberately not looked at here.
        if (grant_i) begin
          state_d     = IBUSY;
          mem_req_d   = 1'b1;
          mem_write_d = 1'b0;
          mem_size_d  = 2'b10;
          mem_addr_d  = i_addr;
          mem_wdata_d = 32'h0;
          starve_d    = 4'd0;
          tmo_d       = 8'd0;
        end else if (grant_d) begin
          state_d     = DBUSY;
          mem_req_d   = 1'b1;
          mem_write_d = d_write;
          mem_size_d  = d_size;
          mem_addr_d  = d_addr;
          mem_wdata_d = d_wdata;
          tmo_d       = 8'd0;
          // Count only D grants that pass over a fetch that is really waiting.
          if (i_req_eff && (starve_q != STARVE_MAX)) begin
            starve_d = starve_q + 4'd1;
          end
        end
      end

      IBUSY, DBUSY: begin
        if (!mem_ack_n) begin
          state_d     = IDLE;
          mem_req_d   = 1'b0;
          mem_write_d = 1'b0;
          tmo_d       = 8'd0;
          if (state_q == IBUSY) begin
            i_rdata_d = mem_rdata;
            i_ready_d = 1'b1;
          end else begin
            d_ready_d = 1'b1;
            if (!mem_write_q) begin
              d_rdata_d = mem_rdata;
            end
          end
        end else if (tmo_q == TMO_LAST) begin
          // Abort: finish the requester with zeroed data so the pipeline
          // does not stall forever on a dead bus.
          state_d     = IDLE;
          mem_req_d   = 1'b0;
          mem_write_d = 1'b0;
          tmo_d       = 8'd0;
          bus_err_d   = 1'b1;
          if (state_q == IBUSY) begin
            i_rdata_d = 32'h0;
            i_ready_d = 1'b1;
          end else begin
            d_rdata_d = 32'h0;
            d_ready_d = 1'b1;
          end
        end else begin
          tmo_d = tmo_q + 8'd1;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_x) begin
    if (!reset_x) begin
      state_q     <= IDLE;
      starve_q    <= 4'd0;
      tmo_q       <= 8'd0;
      i_rdata_q   <= 32'h0;
      d_rdata_q   <= 32'h0;
      i_ready_q   <= 1'b0;
      d_ready_q   <= 1'b0;
      bus_err_q   <= 1'b0;
      mem_req_q   <= 1'b0;
      mem_write_q <= 1'b0;
      mem_size_q  <= 2'b00;
      mem_addr_q  <= 32'h0;
      mem_wdata_q <= 32'h0;
    end else begin
      state_q     <= state_d;
      starve_q    <= starve_d;
      tmo_q       <= tmo_d;
      i_rdata_q   <= i_rdata_d;
      d_rdata_q   <= d_rdata_d;
      i_ready_q   <= i_ready_d;
      d_ready_q   <= d_ready_d;
      bus_err_q   <= bus_err_d;
      mem_req_q   <= mem_req_d;
      mem_write_q <= mem_write_d;
      mem_size_q  <= mem_size_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
    end
  end

  assign i_rdata   = i_rdata_q;
  assign d_rdata   = d_rdata_q;
  assign i_ready   = i_ready_q;
  assign d_ready   = d_ready_q;
  assign bus_err   = bus_err_q;
  assign mem_req   = mem_req_q;
  assign mem_write = mem_write_q;
  assign mem_size  = mem_size_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign busy      = (state_q == IBUSY) || (state_q == DBUSY);

endmodule

// File: tb/tb_mem_bus_arbiter.sv
module tb_mem_bus_arbiter;

  localparam int STARVE_LIMIT = 4;
  localparam int TIMEOUT      = 64;

  // ---------------- clock / reset ----------------
  logic        clk = 1'b0;
  logic        reset_x;
  always #5 clk = ~clk;

  logic        i_req;
  logic [31:0] i_addr;
  logic [31:0] i_rdata;
  logic        i_ready;
  logic        d_req;
  logic        d_write;
  logic [1:0]  d_size;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic [31:0] d_rdata;
  logic        d_ready;
  logic        mem_req;
  logic        mem_write;
  logic [1:0]  mem_size;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ack_n;
  logic        bus_err;
  logic        busy;

  mem_bus_arbiter #(.STARVE_LIMIT(STARVE_LIMIT), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset_x(reset_x),
    .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata), .i_ready(i_ready),
    .d_req(d_req), .d_write(d_write), .d_size(d_size), .d_addr(d_addr),
    .d_wdata(d_wdata), .d_rdata(d_rdata), .d_ready(d_ready),
    .mem_req(mem_req), .mem_write(mem_write), .mem_size(mem_size),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .mem_ack_n(mem_ack_n), .bus_err(bus_err), .busy(busy)
  );

  // ---------------- scoreboard state ----------------
  int total = 0;
  int bad   = 0;
  logic [34:0] rsp_q[$];  // {bus_err, side_is_d, rdata_known, rdata}
  logic [66:0] bus_q[$];  // {write, size, addr, wdata}
  logic [31:0] last_d_rdata = 32'h0;
  logic [34:0] rsp_e;
  logic [66:0] bus_e, bus_cap, bus_act;
  logic        prev_req = 1'b0;
  int          req_hi_cnt = 0;
  int          cyc;

  // memory responder controls
  int wait_n   = 0;
  bit no_ack   = 1'b0;
  bit idle_ack = 1'b0;
  int busy_cyc = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, want);
    end
  endtask

  function automatic logic [31:0] mem_model(input logic [31:0] a);
    if (a == 32'h0000_0100) return 32'h0000_0013;
    return a ^ 32'h5A5A_0000;
  endfunction

  function automatic void exp_fetch(input logic [31:0] a);
    bus_q.push_back({1'b0, 2'b10, a, 32'h0});
    rsp_q.push_back({1'b0, 1'b0, 1'b1, mem_model(a)});
  endfunction

  function automatic void exp_data(input logic w, input logic [1:0] sz,
                                   input logic [31:0] a, input logic [31:0] wd);
    bus_q.push_back({w, sz, a, wd});
    rsp_q.push_back({1'b0, 1'b1, ~w, (w ? 32'h0 : mem_model(a))});
  endfunction

  // ---------------- memory responder ----------------
  always @(negedge clk) begin
    if (mem_req) begin
      mem_ack_n = (busy_cyc == wait_n && !no_ack) ? 1'b0 : 1'b1;
      mem_rdata = mem_model(mem_addr);
      busy_cyc++;
    end else begin
      mem_ack_n = idle_ack ? 1'b0 : 1'b1;
      mem_rdata = 32'hBAD0_0000;
      busy_cyc  = 0;
    end
  end

  // ---------------- response monitor ----------------
  always @(negedge clk) begin
    if (!reset_x) begin
      last_d_rdata = 32'h0;
    end else if (i_ready || d_ready || bus_err) begin
      if (rsp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_rsp: i_ready=%b d_ready=%b bus_err=%b, none outstanding",
                 i_ready, d_ready, bus_err);
      end else begin
        rsp_e = rsp_q.pop_front();
        check("rsp_flags", {29'h0, bus_err, i_ready, d_ready},
              {29'h0, rsp_e[34], ~rsp_e[33], rsp_e[33]});
        check("rsp_rdata", rsp_e[33] ? d_rdata : i_rdata,
              rsp_e[32] ? rsp_e[31:0] : last_d_rdata);
        if (rsp_e[33] && rsp_e[32]) last_d_rdata = rsp_e[31:0];
      end
    end
  end

  // ---------------- bus monitor ----------------
  always @(negedge clk) begin
    if (!reset_x) begin
      prev_req = 1'b0;
    end else begin
      bus_act = {mem_write, mem_size, mem_addr, mem_wdata};
      if (mem_req && !prev_req) begin
        req_hi_cnt = 1;
        bus_cap    = bus_act;
        if (bus_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_grant: addr %h write %b", mem_addr, mem_write);
        end else begin
          bus_e = bus_q.pop_front();
          check("bus_write", 32'(mem_write), 32'(bus_e[66]));
          check("bus_size",  32'(mem_size),  32'(bus_e[65:64]));
          check("bus_addr",  mem_addr,       bus_e[63:32]);
          check("bus_wdata", mem_wdata,      bus_e[31:0]);
        end
      end else if (mem_req) begin
        req_hi_cnt++;
        total++;
        if (bus_act !== bus_cap) begin
          bad++;
          $display("FAIL bus_stable: got %h expected %h", bus_act, bus_cap);
        end
      end
      if (mem_req || busy) check("busy_vs_req", 32'(busy), 32'(mem_req));
      prev_req = mem_req;
    end
  end

  // ---------------- driver helpers ----------------
  task automatic wait_rdy(input bit side_d, input string name, output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(side_d ? d_ready : i_ready) && n < 200);
    if (!(side_d ? d_ready : i_ready)) begin
      total++;
      bad++;
      $display("FAIL %s: no ready after %0d cycles", name, n);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_mem_req"},   32'(mem_req),   32'h0);
    check({tag, "_mem_write"}, 32'(mem_write), 32'h0);
    check({tag, "_mem_size"},  32'(mem_size),  32'h0);
    check({tag, "_mem_addr"},  mem_addr,       32'h0);
    check({tag, "_mem_wdata"}, mem_wdata,      32'h0);
    check({tag, "_i_rdata"},   i_rdata,        32'h0);
    check({tag, "_d_rdata"},   d_rdata,        32'h0);
    check({tag, "_readys"},    {30'h0, i_ready, d_ready}, 32'h0);
    check({tag, "_bus_err"},   32'(bus_err),   32'h0);
    check({tag, "_busy"},      32'(busy),      32'h0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    reset_x = 1'b0;
    i_req = 1'b0; i_addr = 32'h0;
    d_req = 1'b0; d_write = 1'b0; d_size = 2'b00; d_addr = 32'h0; d_wdata = 32'h0;
    repeat (3) @(negedge clk);
    check_all_zero("por");
    #2 reset_x = 1'b1;

    // Reset in the middle of a data access
    wait_n = 20;
    @(negedge clk);
    d_req = 1'b1; d_write = 1'b0; d_size = 2'b00; d_addr = 32'h0000_2000; d_wdata = 32'h0;
    bus_q.push_back({1'b0, 2'b00, 32'h0000_2000, 32'h0});
    @(negedge clk);
    check("pre_rst_mem_req", 32'(mem_req), 32'h1);
    @(negedge clk);
    #2 reset_x = 1'b0;
    #1 check_all_zero("mid_rst");
    d_req = 1'b0;
    @(negedge clk);
    #2 reset_x = 1'b1;
    wait_n = 0;
    repeat (4) @(negedge clk);
    check("post_rst_busy", 32'(busy), 32'h0);

    // Acknowledge while idle is ignored
    idle_ack = 1'b1;
    repeat (4) begin
      @(negedge clk);
      check("idle_ack_busy", 32'(busy), 32'h0);
    end
    idle_ack = 1'b0;
    @(negedge clk);

    // Single fetch, zero wait
    i_req = 1'b1; i_addr = 32'h0000_0100; d_size = 2'b01;
    exp_fetch(32'h0000_0100);
    wait_rdy(1'b0, "fetch_rdy", cyc);
    check("fetch_latency", 32'(cyc), 32'd2);
    check("fetch_req_cycles", 32'(req_hi_cnt), 32'd1);
    @(negedge clk);
    i_req = 1'b0;
    @(negedge clk);

    // Starvation: D keeps coming back, fetch waits
    d_req = 1'b1; d_write = 1'b0; d_size = 2'b00; d_wdata = 32'h1111_2222;
    d_addr = 32'h0000_3000;
    i_req = 1'b1; i_addr = 32'h0000_0400;
    for (int k = 0; k < 4; k++) exp_data(1'b0, 2'b00, 32'h0000_3000 + 32'(k) * 32'h10, 32'h1111_2222);
    exp_fetch(32'h0000_0400);
    exp_data(1'b0, 2'b00, 32'h0000_3040, 32'h1111_2222);
    for (int k = 0; k < 4; k++) begin
      wait_rdy(1'b1, "starve_d_rdy", cyc);
      i_req  = 1'b0;
      d_addr = 32'h0000_3000 + 32'(k + 1) * 32'h10;
      @(negedge clk);
      i_req = 1'b1;
    end
    wait_rdy(1'b0, "starve_i_rdy", cyc);
    check("starve_i_latency", 32'(cyc), 32'd2);
    i_req = 1'b0;
    wait_rdy(1'b1, "starve_d5_rdy", cyc);
    @(negedge clk);
    d_req = 1'b0;
    @(negedge clk);

    // Contention: store and fetch together, one wait state each
    wait_n = 1;
    d_req = 1'b1; d_write = 1'b1; d_size = 2'b10; d_addr = 32'h0000_1000; d_wdata = 32'hDEAD_BEEF;
    i_req = 1'b1; i_addr = 32'h0000_0200;
    exp_data(1'b1, 2'b10, 32'h0000_1000, 32'hDEAD_BEEF);
    exp_fetch(32'h0000_0200);
    wait_rdy(1'b1, "cont_d_rdy", cyc);
    check("cont_d_latency", 32'(cyc), 32'd3);
    @(negedge clk);
    d_req = 1'b0;
    check("cont_i_granted", 32'(busy), 32'h1);
    wait_rdy(1'b0, "cont_i_rdy", cyc);
    check("cont_i_after_d", 32'(cyc + 1), 32'd3);
    @(negedge clk);
    i_req = 1'b0;
    @(negedge clk);

    // Wait states: ack after 5 busy cycles
    wait_n = 5;
    d_req = 1'b1; d_write = 1'b0; d_size = 2'b01; d_addr = 32'h0000_0500; d_wdata = 32'h0;
    exp_data(1'b0, 2'b01, 32'h0000_0500, 32'h0);
    wait_rdy(1'b1, "wait_rdy", cyc);
    check("wait_latency", 32'(cyc), 32'd7);
    check("wait_req_cycles", 32'(req_hi_cnt), 32'd6);
    @(negedge clk);
    d_req = 1'b0;
    @(negedge clk);

    // Timeout on a load
    wait_n = 0; no_ack = 1'b1;
    d_req = 1'b1; d_write = 1'b0; d_size = 2'b10; d_addr = 32'h0000_0600; d_wdata = 32'h0;
    bus_q.push_back({1'b0, 2'b10, 32'h0000_0600, 32'h0});
    rsp_q.push_back({1'b1, 1'b1, 1'b1, 32'h0});
    wait_rdy(1'b1, "tmo_rdy", cyc);
    check("tmo_latency", 32'(cyc), 32'(TIMEOUT + 1));
    check("tmo_req_cycles", 32'(req_hi_cnt), 32'(TIMEOUT));
    @(negedge clk);
    d_req = 1'b0; no_ack = 1'b0;
    @(negedge clk);

    // Normal service after the abort
    i_req = 1'b1; i_addr = 32'h0000_0700;
    exp_fetch(32'h0000_0700);
    wait_rdy(1'b0, "post_tmo_i_rdy", cyc);
    check("post_tmo_i_latency", 32'(cyc), 32'd2);
    @(negedge clk);
    i_req = 1'b0;
    d_req = 1'b1; d_write = 1'b0; d_size = 2'b00; d_addr = 32'h0000_0800;
    exp_data(1'b0, 2'b00, 32'h0000_0800, 32'h0);
    wait_rdy(1'b1, "post_tmo_d_rdy", cyc);
    check("post_tmo_d_latency", 32'(cyc), 32'd2);
    @(negedge clk);
    d_req = 1'b0;
    repeat (4) @(negedge clk);

    check("rsp_q_drained", 32'(rsp_q.size()), 32'h0);
    check("bus_q_drained", 32'(bus_q.size()), 32'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // ---------------- watchdog ----------------
  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

endmodule
